// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-ported register file for the dual-issue pipeline.
// Writes land on the rising edge. Reads are combinational and see same-cycle writes.
// When ports collide on one address, the highest-indexed write port wins.
// Optional busy scoreboard is built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_a,
  output logic [NUM_RD-1:0]        busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regFile [DEPTH];

  // Storage update: later ports are assigned last, so the youngest slot wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regFile[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == '0))) begin
          r_regFile[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_busyBits;

  // Busy tracking: writes clear, allocs set afterwards so a new producer overrides the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busyBits <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j]) begin
          r_busyBits[wa[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (alloc_en[k] && !((ZERO_REG != 0) && (alloc_a[k*ADDR_W +: ADDR_W] == '0))) begin
          r_busyBits[alloc_a[k*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
    end
  end
`else
  logic w_unusedAlloc;
  assign w_unusedAlloc = ^{alloc_en, alloc_a};
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rdPort
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_hit;
    logic              w_isZero;

    assign w_addr   = ra[i*ADDR_W +: ADDR_W];
    assign w_isZero = (ZERO_REG != 0) && (w_addr == '0);

    // Read resolution: storage, overridden by youngest matching write, overridden by hard zero
    always_comb begin
      w_data = r_regFile[w_addr];
      w_hit  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == w_addr)) begin
          w_data = wd[j*DATA_W +: DATA_W];
          w_hit  = 1'b1;
        end
      end
      if (w_isZero) begin
        w_data = '0;
      end
    end

    assign rd[i*DATA_W +: DATA_W] = w_data;

`ifdef REGFILE_SCOREBOARD_EN
    assign busy[i] = r_busyBits[w_addr] & ~w_hit & ~w_isZero;
`else
    logic w_unusedHit;
    assign w_unusedHit = w_hit;
    assign busy[i]     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomised checks of regfile_mp.
// A second small instance with ZERO_REG=0 covers the ordinary register-0 case.
// Scoreboard expectations follow REGFILE_SCOREBOARD_EN when it is defined.
module tb_regfile_mp;

  logic         clk;
  logic         rst;
  logic [19:0]  ra;
  logic [127:0] rd;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [63:0]  wd;
  logic [1:0]   allocEn;
  logic [9:0]   allocA;
  logic [3:0]   busy;

  logic [4:0]   zRa;
  logic [31:0]  zRd;
  logic [0:0]   zWe;
  logic [4:0]   zWa;
  logic [31:0]  zWd;
  logic [0:0]   zAllocEn;
  logic [4:0]   zAllocA;
  logic [0:0]   zBusy;

  int nChecks;
  int nFails;

  logic [31:0] mRf   [32];
  logic        mBusy [32];

  regfile_mp dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .alloc_en(allocEn), .alloc_a(allocA), .busy(busy)
  );

  regfile_mp #(.NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dutZ (
    .clk(clk), .rst(rst), .ra(zRa), .rd(zRd), .we(zWe), .wa(zWa), .wd(zWd),
    .alloc_en(zAllocEn), .alloc_a(zAllocA), .busy(zBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] getRd(input int i);
    return rd[i*32 +: 32];
  endfunction

  task automatic setRa(input int i, input logic [4:0] a);
    ra[i*5 +: 5] = a;
  endtask

  task automatic idleInputs();
    we      = '0;
    wa      = '0;
    wd      = '0;
    allocEn = '0;
    allocA  = '0;
    zWe     = '0;
    zWa     = '0;
    zWd     = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idleInputs();
    we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h1234;
    for (int i = 0; i < 4; i++) setRa(i, 5'd5);
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (getRd(0) !== 32'h1234) begin
      nFails++;
      $display("[TB] FAIL reset_preload: got %h expected %h", getRd(0), 32'h1234);
    end
    rst = 1'b1;
    we = 2'b10; wa[9:5] = 5'd5; wd[63:32] = 32'hFFFF;
    allocEn = 2'b01; allocA[4:0] = 5'd5;
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    #1;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (getRd(i) !== 32'h0) begin
        nFails++;
        $display("[TB] FAIL reset_rd%0d: got %h expected 0", i, getRd(i));
      end
    end
    nChecks++;
    if (busy !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL reset_busy: got %b expected 0000", busy);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idleInputs();
    for (int i = 0; i < 4; i++) setRa(i, 5'd0);
    setRa(2, 5'd3);
    we = 2'b01; wa[4:0] = 5'd3; wd[31:0] = 32'hDEADBEEF;
    #1;
    nChecks++;
    if (getRd(2) !== 32'hDEADBEEF) begin
      nFails++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected DEADBEEF", getRd(2));
    end
    nChecks++;
    if (getRd(1) !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL bypass_other_port: got %h expected 0", getRd(1));
    end
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (getRd(2) !== 32'hDEADBEEF) begin
      nFails++;
      $display("[TB] FAIL bypass_stored: got %h expected DEADBEEF", getRd(2));
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idleInputs();
    setRa(0, 5'd7);
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2, 32'h1};
    #1;
    nChecks++;
    if (getRd(0) !== 32'h2) begin
      nFails++;
      $display("[TB] FAIL collision_bypass: got %h expected 2", getRd(0));
    end
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (getRd(0) !== 32'h2) begin
      nFails++;
      $display("[TB] FAIL collision_stored: got %h expected 2", getRd(0));
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idleInputs();
    for (int i = 0; i < 4; i++) setRa(i, 5'd0);
    we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'hAAAA, 32'hAAAA};
    zWe = 1'b1; zWa = 5'd0; zWd = 32'hAAAA; zRa = 5'd0;
    #1;
    nChecks++;
    if (getRd(0) !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL zero_same_cycle: got %h expected 0", getRd(0));
    end
    nChecks++;
    if (zRd !== 32'hAAAA) begin
      nFails++;
      $display("[TB] FAIL zero_off_bypass: got %h expected AAAA", zRd);
    end
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (getRd(3) !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL zero_after: got %h expected 0", getRd(3));
    end
    nChecks++;
    if (zRd !== 32'hAAAA) begin
      nFails++;
      $display("[TB] FAIL zero_off_stored: got %h expected AAAA", zRd);
    end
  endtask

  task automatic test_all_ports();
    @(negedge clk);
    idleInputs();
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'h22, 32'h11};
    @(negedge clk);
    we = 2'b11; wa = {5'd4, 5'd3}; wd = {32'h44, 32'h33};
    @(negedge clk);
    idleInputs();
    ra = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    nChecks++;
    if (rd !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
      nFails++;
      $display("[TB] FAIL all_ports: got %h expected 00000044000000330000002200000011", rd);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idleInputs();
    for (int i = 0; i < 4; i++) setRa(i, 5'd9);
    setRa(3, 5'd0);
    allocEn = 2'b01; allocA[4:0] = 5'd9;
    @(negedge clk);
    idleInputs();
    allocEn = 2'b11; allocA = {5'd0, 5'd0};
    #1;
`ifdef REGFILE_SCOREBOARD_EN
    nChecks++;
    if (busy[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL sb_alloc: got %b expected 1", busy[0]);
    end
    @(negedge clk);
    idleInputs();
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h99;
    allocEn = 2'b10; allocA[9:5] = 5'd9;
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (busy[1] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL sb_set_wins: got %b expected 1", busy[1]);
    end
    nChecks++;
    if (busy[3] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL sb_reg0: got %b expected 0", busy[3]);
    end
    @(negedge clk);
    we = 2'b10; wa[9:5] = 5'd9; wd[63:32] = 32'h98;
    #1;
    nChecks++;
    if (busy[2] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL sb_write_cycle: got %b expected 0", busy[2]);
    end
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (busy !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL sb_after_write: got %b expected 0000", busy);
    end
`else
    nChecks++;
    if (busy !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL sb_disabled: got %b expected 0000", busy);
    end
    @(negedge clk);
    idleInputs();
    #1;
    nChecks++;
    if (busy !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL sb_disabled_after: got %b expected 0000", busy);
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] expData;
    logic        expBusy;
    logic        hit;
    @(negedge clk);
    idleInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      mRf[r]   = '0;
      mBusy[r] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 99) == 0);
      we      = 2'($urandom_range(0, 3));
      allocEn = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wa[j*5 +: 5]     = 5'($urandom_range(0, 7));
        wd[j*32 +: 32]   = $urandom;
        allocA[j*5 +: 5] = 5'($urandom_range(0, 7));
      end
      for (int i = 0; i < 4; i++) setRa(i, 5'($urandom_range(0, 7)));
      #1;
      for (int i = 0; i < 4; i++) begin
        a       = ra[i*5 +: 5];
        hit     = 1'b0;
        expData = mRf[a];
        if (we[0] && wa[4:0] == a) begin
          expData = wd[31:0];
          hit     = 1'b1;
        end
        if (we[1] && wa[9:5] == a) begin
          expData = wd[63:32];
          hit     = 1'b1;
        end
        if (a == 5'd0) expData = '0;
`ifdef REGFILE_SCOREBOARD_EN
        expBusy = (a != 5'd0) && mBusy[a] && !hit;
`else
        expBusy = 1'b0;
`endif
        nChecks++;
        if (getRd(i) !== expData) begin
          nFails++;
          $display("[TB] FAIL rand_rd%0d cycle %0d: got %h expected %h", i, c, getRd(i), expData);
        end
        nChecks++;
        if (busy[i] !== expBusy) begin
          nFails++;
          $display("[TB] FAIL rand_busy%0d cycle %0d: got %b expected %b", i, c, busy[i], expBusy);
        end
      end
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mRf[r]   = '0;
          mBusy[r] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (we[j] && wa[j*5 +: 5] != 5'd0) mRf[wa[j*5 +: 5]] = wd[j*32 +: 32];
        end
        for (int j = 0; j < 2; j++) begin
          if (we[j]) mBusy[wa[j*5 +: 5]] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
          if (allocEn[k] && allocA[k*5 +: 5] != 5'd0) mBusy[allocA[k*5 +: 5]] = 1'b1;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
  endtask

  initial begin
    nChecks  = 0;
    nFails   = 0;
    rst      = 1'b1;
    ra       = '0;
    zRa      = '0;
    zAllocEn = '0;
    zAllocA  = '0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] starting directed tests");
    test_reset();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_all_ports();
    test_scoreboard();
    $display("[TB] starting random run");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
